// File: rtl/sm_alu_pkg.sv
// rtl/sm_alu_pkg.sv - shared op encodings, FSM state type and width helper for sm_alu_seq
package sm_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Magnitude bit count for a sign-magnitude word of the given width.
    function automatic int mag_bits(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/sm_alu_iter.sv
// rtl/sm_alu_iter.sv - M-step shift-add multiplier / restoring divider core
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (aborts any iteration)
//   start_i      load operands and perform the first step on this edge
//   div_i        1 = divide, 0 = multiply (sampled with start_i)
//   ma_i, mb_i   unsigned operand magnitudes (M bits)
//   done_o       all M steps done; mag_o/rem_o hold the final values
//   mag_o        product (2M bits) or zero-extended quotient
//   rem_o        division remainder, 0 when multiplying
module sm_alu_iter #(
    parameter int M = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic           div_i,
    input  logic [M-1:0]   ma_i,
    input  logic [M-1:0]   mb_i,
    output logic           done_o,
    output logic [2*M-1:0] mag_o,
    output logic [M-1:0]   rem_o
);
    import sm_alu_pkg::*;

    localparam int             CW       = $clog2(M + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(M);

    logic           busy_q;
    logic           div_q;
    logic [CW-1:0]  cnt_q;
    // acc_q is the product accumulator when multiplying; when dividing its low
    // M bits are the dividend shifting out the top while quotient bits enter
    // at the bottom.
    logic [2*M-1:0] acc_q;
    logic [2*M-1:0] mcand_q;
    logic [M-1:0]   mplier_q;
    logic [M-1:0]   part_q;
    logic [M-1:0]   dvsr_q;

    logic           s_div;
    logic [2*M-1:0] s_acc, s_mcand, n_acc, n_mcand;
    logic [M-1:0]   s_mplier, s_part, s_dvsr, n_mplier, n_part;
    logic [M:0]     shifted;
    logic [M-1:0]   diff;

    // The start edge already performs step 1, so M steps finish M-1 edges
    // after start and the caller can finalise on the following edge.
    always_comb begin
        if (start_i) begin
            s_div    = div_i;
            s_acc    = div_i ? {{M{1'b0}}, ma_i} : '0;
            s_mcand  = {{M{1'b0}}, mb_i};
            s_mplier = ma_i;
            s_part   = '0;
            s_dvsr   = mb_i;
        end else begin
            s_div    = div_q;
            s_acc    = acc_q;
            s_mcand  = mcand_q;
            s_mplier = mplier_q;
            s_part   = part_q;
            s_dvsr   = dvsr_q;
        end

        n_acc    = s_acc;
        n_mcand  = s_mcand;
        n_mplier = s_mplier;
        n_part   = s_part;

        shifted  = {s_part, s_acc[M-1]};
        // Partial remainder stays below the divisor, so M bits hold the difference.
        diff     = shifted[M-1:0] - s_dvsr;

        if (s_div) begin
            if (shifted >= {1'b0, s_dvsr}) begin
                n_part = diff;
                n_acc  = {s_acc[2*M-1:M], s_acc[M-2:0], 1'b1};
            end else begin
                n_part = shifted[M-1:0];
                n_acc  = {s_acc[2*M-1:M], s_acc[M-2:0], 1'b0};
            end
        end else begin
            n_acc    = s_mplier[0] ? (s_acc + s_mcand) : s_acc;
            n_mcand  = s_mcand << 1;
            n_mplier = s_mplier >> 1;
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_LAST);
    assign mag_o  = acc_q;
    assign rem_o  = div_q ? part_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            part_q   <= '0;
            dvsr_q   <= '0;
        end else if (start_i || (busy_q && (cnt_q != CNT_LAST))) begin
            busy_q   <= 1'b1;
            div_q    <= s_div;
            cnt_q    <= start_i ? CW'(1) : (cnt_q + 1'b1);
            acc_q    <= n_acc;
            mcand_q  <= n_mcand;
            mplier_q <= n_mplier;
            part_q   <= n_part;
            dvsr_q   <= s_dvsr;
        end else if (done_o) begin
            busy_q   <= 1'b0;
        end
    end

endmodule

// File: rtl/sm_alu_seq.sv
// rtl/sm_alu_seq.sv - sequential sign-magnitude ALU with handshaked operand/result beats
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand beat handshake (a, b, sel)
//   a, b                 sign-magnitude operands, sign in bit WIDTH-1
//   sel                  0 add, 1 sub, 2 mul, 3 div, 4 shl, 5 shr, 6-7 illegal
//   out_valid/out_ready  result beat handshake
//   result               sign in bit 2M, magnitude in [2M-1:0]
//   rem                  division remainder magnitude
//   div_zero, bad_op     divide-by-zero and illegal-op flags
module sm_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-2:0] result,
    output logic [WIDTH-2:0]   rem,
    output logic               div_zero,
    output logic               bad_op
);
    import sm_alu_pkg::*;

    localparam int M = mag_bits(WIDTH);

    state_e         state_q;
    logic           in_ready_q, out_valid_q, div_zero_q, bad_op_q;
    logic           sx_q;
    logic [2*M:0]   result_q;
    logic [M-1:0]   rem_q;

    logic           sa, sb, sb_eff;
    logic [M-1:0]   ma, mb;
    logic           accept;
    logic           is_iter;
    logic           q_sign, q_dz, q_bad;
    logic [2*M-1:0] q_mag;

    logic           iter_done;
    logic [2*M-1:0] iter_mag;
    logic [M-1:0]   iter_rem;

    assign sa     = a[WIDTH-1];
    assign sb     = b[WIDTH-1];
    assign ma     = a[M-1:0];
    assign mb     = b[M-1:0];
    // Subtraction is addition with b's sign flipped.
    assign sb_eff = (sel == OP_SUB) ? ~sb : sb;
    assign accept = in_valid && in_ready_q;

    // Single-cycle ops are evaluated straight from the accepted beat.
    always_comb begin
        is_iter = 1'b0;
        q_sign  = 1'b0;
        q_mag   = '0;
        q_dz    = 1'b0;
        q_bad   = 1'b0;
        case (sel)
            OP_ADD, OP_SUB: begin
                if (sa == sb_eff) begin
                    q_mag  = {{M{1'b0}}, ma} + {{M{1'b0}}, mb};
                    q_sign = sa;
                end else if (ma >= mb) begin
                    q_mag  = {{M{1'b0}}, ma - mb};
                    q_sign = sa;
                end else begin
                    q_mag  = {{M{1'b0}}, mb - ma};
                    q_sign = sb_eff;
                end
            end
            OP_MUL: is_iter = 1'b1;
            OP_DIV: begin
                if (mb == '0) begin
                    q_mag  = '1;
                    q_sign = sa ^ sb;
                    q_dz   = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            OP_SHL: begin
                q_mag  = {{(M-1){1'b0}}, ma, 1'b0};
                q_sign = sa;
            end
            OP_SHR: begin
                q_mag  = {{M{1'b0}}, 1'b0, ma[M-1:1]};
                q_sign = sa;
            end
            default: q_bad = 1'b1;
        endcase
    end

    sm_alu_iter #(.M(M)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && is_iter),
        .div_i   (sel == OP_DIV),
        .ma_i    (ma),
        .mb_i    (mb),
        .done_o  (iter_done),
        .mag_o   (iter_mag),
        .rem_o   (iter_rem)
    );

    // Zero magnitudes are forced positive on every path into result_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rem_q       <= '0;
            div_zero_q  <= 1'b0;
            bad_op_q    <= 1'b0;
            sx_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (is_iter) begin
                            state_q <= ST_EXEC;
                            sx_q    <= sa ^ sb;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= {q_sign & (|q_mag), q_mag};
                            rem_q       <= '0;
                            div_zero_q  <= q_dz;
                            bad_op_q    <= q_bad;
                        end
                    end
                end
                ST_EXEC: begin
                    if (iter_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= {sx_q & (|iter_mag), iter_mag};
                        rem_q       <= iter_rem;
                        div_zero_q  <= 1'b0;
                        bad_op_q    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // in_ready rises only after the result handshake edge.
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rem       = rem_q;
    assign div_zero  = div_zero_q;
    assign bad_op    = bad_op_q;

endmodule

// File: tb/tb_sm_alu_seq.sv
// tb/tb_sm_alu_seq.sv - directed self-checking bench for sm_alu_seq (WIDTH=8)
module tb_sm_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] result;
    logic [6:0]  rem;
    logic        div_zero;
    logic        bad_op;

    int tests = 0;
    int fails = 0;

    sm_alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rem       (rem),
        .div_zero  (div_zero),
        .bad_op    (bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand beat, scramble the inputs after acceptance, and count
    // negedges until out_valid appears (bounded).
    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic [2:0] op_sel,
                         output int lat, output logic rdy_seen);
        @(negedge clk);
        a = op_a; b = op_b; sel = op_sel; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = ~op_a; b = ~op_b; sel = 3'd7;
        lat = 0;
        rdy_seen = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_seen = 1'b1;
            if (out_valid) break;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if ({result, rem, div_zero, bad_op} !== 24'd0)
            begin fails++; $display("FAIL reset_outputs got res=%h rem=%h dz=%b bad=%b want 0", result, rem, div_zero, bad_op); end
    endtask

    task automatic test_add_sub();
        int lat; logic rs;
        do_op(8'h85, 8'h03, 3'd0, lat, rs);
        tests++; if (lat !== 1) begin fails++; $display("FAIL add_latency got %0d want 1", lat); end
        tests++; if (result !== 15'h4002) begin fails++; $display("FAIL add_neg got %h want 4002", result); end
        release_result();
        do_op(8'h03, 8'h03, 3'd1, lat, rs);
        tests++; if (result !== 15'h0000) begin fails++; $display("FAIL sub_tie got %h want 0000", result); end
        release_result();
        do_op(8'h83, 8'h03, 3'd0, lat, rs);
        tests++; if (result !== 15'h0000) begin fails++; $display("FAIL add_negzero got %h want 0000", result); end
        release_result();
        do_op(8'h7F, 8'h7F, 3'd0, lat, rs);
        tests++; if (result !== 15'h00FE) begin fails++; $display("FAIL add_carry got %h want 00FE", result); end
        release_result();
        do_op(8'h05, 8'h09, 3'd1, lat, rs);
        tests++; if (result !== 15'h4004) begin fails++; $display("FAIL sub_neg got %h want 4004", result); end
        release_result();
    endtask

    task automatic test_mul();
        int lat; logic rs;
        do_op(8'hFF, 8'h7F, 3'd2, lat, rs);
        tests++; if (lat !== 8) begin fails++; $display("FAIL mul_latency got %0d want 8", lat); end
        tests++; if (rs !== 1'b0) begin fails++; $display("FAIL mul_in_ready got %b want 0", rs); end
        tests++; if (result !== 15'h7F01 || rem !== 7'd0)
            begin fails++; $display("FAIL mul_result got %h rem %h want 7F01 rem 00", result, rem); end
        release_result();
        do_op(8'h85, 8'h00, 3'd2, lat, rs);
        tests++; if (result !== 15'h0000) begin fails++; $display("FAIL mul_zero got %h want 0000", result); end
        release_result();
    endtask

    task automatic test_div();
        int lat; logic rs;
        do_op(8'h64, 8'h87, 3'd3, lat, rs);
        tests++; if (lat !== 8) begin fails++; $display("FAIL div_latency got %0d want 8", lat); end
        tests++; if (result !== 15'h400E) begin fails++; $display("FAIL div_quot got %h want 400E", result); end
        tests++; if (rem !== 7'd2 || div_zero !== 1'b0)
            begin fails++; $display("FAIL div_rem got rem=%0d dz=%b want 2 0", rem, div_zero); end
        release_result();
        do_op(8'h05, 8'h87, 3'd3, lat, rs);
        tests++; if (result !== 15'h0000 || rem !== 7'd5)
            begin fails++; $display("FAIL div_small got %h rem %0d want 0000 rem 5", result, rem); end
        release_result();
    endtask

    task automatic test_div_zero_bad_op();
        int lat; logic rs;
        do_op(8'h05, 8'h80, 3'd3, lat, rs);
        tests++; if (lat !== 1) begin fails++; $display("FAIL divzero_latency got %0d want 1", lat); end
        tests++; if (result !== 15'h7FFF || rem !== 7'd0 || div_zero !== 1'b1 || bad_op !== 1'b0)
            begin fails++; $display("FAIL divzero got %h rem %h dz %b bad %b want 7FFF 00 1 0", result, rem, div_zero, bad_op); end
        release_result();
        do_op(8'h85, 8'h03, 3'd6, lat, rs);
        tests++; if (result !== 15'h0000 || bad_op !== 1'b1 || div_zero !== 1'b0)
            begin fails++; $display("FAIL bad_op got %h bad %b dz %b want 0000 1 0", result, bad_op, div_zero); end
        release_result();
    endtask

    task automatic test_shift();
        int lat; logic rs;
        do_op(8'hC5, 8'h33, 3'd4, lat, rs);
        tests++; if (result !== 15'h408A) begin fails++; $display("FAIL shl got %h want 408A", result); end
        release_result();
        do_op(8'h45, 8'h33, 3'd5, lat, rs);
        tests++; if (result !== 15'h0022) begin fails++; $display("FAIL shr got %h want 0022", result); end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat; logic rs; int bad_cycles;
        do_op(8'h0A, 8'h0B, 3'd2, lat, rs);
        bad_cycles = 0;
        repeat (5) begin
            @(negedge clk);
            if (result !== 15'h006E || out_valid !== 1'b1 || in_ready !== 1'b0) bad_cycles++;
        end
        tests++; if (bad_cycles !== 0)
            begin fails++; $display("FAIL backpressure got %0d unstable cycles (res %h) want 0", bad_cycles, result); end
        release_result();
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin fails++; $display("FAIL after_release got rdy %b vld %b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int lat; logic rs;
        do_op(8'h02, 8'h03, 3'd0, lat, rs);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h09; b = 8'h04; sel = 3'd1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin fails++; $display("FAIL b2b_no_same_cycle got rdy %b vld %b want 1 0", in_ready, out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || result !== 15'h0005)
            begin fails++; $display("FAIL b2b_second got vld %b res %h want 1 0005", out_valid, result); end
        release_result();
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        @(negedge clk);
        a = 8'hFF; b = 8'h7F; sel = 3'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 15'h0000)
            begin fails++; $display("FAIL reset_mid got vld %b rdy %b res %h want 0 1 0000", out_valid, in_ready, result); end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL reset_stale got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_div_zero_bad_op();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
